// File: rtl/fpu_pkg.sv
// Shared FP32 constants, state encoding and classification types for the FPU blocks.
package fpu_pkg;

  localparam int FP_W   = 32;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = 24;
  localparam int INT_W  = 32;

  localparam logic [EXP_W-1:0] EXP_BIAS   = 8'd127;
  // Exponent at which the 24-bit mantissa is already an integer.
  localparam logic [EXP_W-1:0] EXP_ANCHOR = 8'd150;
  localparam logic [EXP_W-1:0] EXP_OVF    = 8'd158;
  localparam logic [EXP_W-1:0] EXP_TINY   = 8'd126;

  localparam logic [INT_W-1:0] SAT_POS = 32'h7FFF_FFFF;
  localparam logic [INT_W-1:0] SAT_NEG = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_ROUND,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    FP_ZERO,
    FP_NORMAL,
    FP_INF,
    FP_NAN
  } fp_class_e;

endpackage

// File: rtl/fp_unpack.sv
// Combinational FP32 field split and classification (zero/denormal, normal, inf, NaN).
module fp_unpack
  import fpu_pkg::*;
(
  input  logic [FP_W-1:0]   fp_i,
  output logic              sign_o,
  output logic [EXP_W-1:0]  exp_o,
  output logic [FRAC_W-1:0] frac_o,
  output fp_class_e         cls_o
);

  always_comb begin
    sign_o = fp_i[FP_W-1];
    exp_o  = fp_i[FP_W-2:FRAC_W];
    frac_o = fp_i[FRAC_W-1:0];
    cls_o  = FP_NORMAL;
    if (exp_o == '0) begin
      cls_o = FP_ZERO;
    end else if (exp_o == '1) begin
      cls_o = (frac_o == '0) ? FP_INF : FP_NAN;
    end
  end

endmodule

// File: rtl/fp_to_int.sv
// FP32 to int32 converter: bit-serial alignment shifter followed by a single
// round-to-nearest-even step, with valid/ready handshakes on both sides.
module fp_to_int
  import fpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FP_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [INT_W-1:0] out_data,
  output logic             out_invalid,
  output logic             out_inexact
);

  state_e             state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [INT_W-1:0]   out_data_q, out_data_d;
  logic               out_invalid_q, out_invalid_d;
  logic               out_inexact_q, out_inexact_d;

  logic [INT_W-1:0]   mant_q, mant_d;
  logic               guard_q, guard_d;
  logic               sticky_q, sticky_d;
  logic               sign_q, sign_d;
  logic               left_q, left_d;
  logic               fixed_q, fixed_d;
  logic [INT_W-1:0]   fix_data_q, fix_data_d;
  logic               fix_inv_q, fix_inv_d;
  logic               fix_inex_q, fix_inex_d;

  logic               u_sign;
  logic [EXP_W-1:0]   u_exp;
  logic [FRAC_W-1:0]  u_frac;
  fp_class_e          u_cls;
  logic [INT_W-1:0]   mag;

  fp_unpack u_unpack (
    .fp_i   (in_data),
    .sign_o (u_sign),
    .exp_o  (u_exp),
    .frac_o (u_frac),
    .cls_o  (u_cls)
  );

  function automatic logic [INT_W-1:0] round_rne(input logic [INT_W-1:0] m,
                                                 input logic g, input logic s);
    logic up;
    up = g & (s | m[0]);
    return m + {{(INT_W-1){1'b0}}, up};
  endfunction

  function automatic logic [INT_W-1:0] sat_value(input logic neg);
    return neg ? SAT_NEG : SAT_POS;
  endfunction

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    out_data_d    = out_data_q;
    out_invalid_d = out_invalid_q;
    out_inexact_d = out_inexact_q;
    mant_d        = mant_q;
    guard_d       = guard_q;
    sticky_d      = sticky_q;
    sign_d        = sign_q;
    left_d        = left_q;
    fixed_d       = fixed_q;
    fix_data_d    = fix_data_q;
    fix_inv_d     = fix_inv_q;
    fix_inex_d    = fix_inex_q;
    mag           = round_rne(mant_q, guard_q, sticky_q);

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sign_d     = u_sign;
          mant_d     = {8'd0, 1'b1, u_frac};
          guard_d    = 1'b0;
          sticky_d   = 1'b0;
          left_d     = (u_exp > EXP_ANCHOR);
          fixed_d    = 1'b1;
          fix_data_d = '0;
          fix_inv_d  = 1'b0;
          fix_inex_d = 1'b0;
          cnt_d      = '0;
          state_d    = S_ROUND;
          case (u_cls)
            FP_NAN: begin
              fix_data_d = SAT_POS;
              fix_inv_d  = 1'b1;
            end
            FP_INF: begin
              fix_data_d = sat_value(u_sign);
              fix_inv_d  = 1'b1;
            end
            FP_ZERO: fix_inex_d = |u_frac;
            default: begin
              if (u_exp >= EXP_OVF) begin
                // -2^31 is the one exp==158 value that fits exactly.
                fix_data_d = sat_value(u_sign);
                fix_inv_d  = !(u_sign && (u_exp == EXP_OVF) && (u_frac == '0));
              end else if (u_exp < EXP_TINY) begin
                fix_inex_d = 1'b1;
              end else begin
                fixed_d = 1'b0;
                if (u_exp > EXP_ANCHOR) begin
                  cnt_d   = 5'(u_exp - EXP_ANCHOR);
                  state_d = S_SHIFT;
                end else if (u_exp < EXP_ANCHOR) begin
                  cnt_d   = 5'(EXP_ANCHOR - u_exp);
                  state_d = S_SHIFT;
                end
              end
            end
          endcase
        end
      end
      S_SHIFT: begin
        if (left_q) begin
          mant_d = {mant_q[INT_W-2:0], 1'b0};
        end else begin
          mant_d   = {1'b0, mant_q[INT_W-1:1]};
          guard_d  = mant_q[0];
          sticky_d = sticky_q | guard_q;
        end
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) state_d = S_ROUND;
      end
      S_ROUND: begin
        if (fixed_q) begin
          out_data_d    = fix_data_q;
          out_invalid_d = fix_inv_q;
          out_inexact_d = fix_inex_q;
        end else begin
          out_data_d    = sign_q ? (~mag + 32'd1) : mag;
          out_invalid_d = 1'b0;
          out_inexact_d = guard_q | sticky_q;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      out_data_q    <= '0;
      out_invalid_q <= 1'b0;
      out_inexact_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      out_data_q    <= out_data_d;
      out_invalid_q <= out_invalid_d;
      out_inexact_q <= out_inexact_d;
    end
  end

  // Working operand registers are always reloaded on accept, so they carry no reset.
  always_ff @(posedge clk) begin
    mant_q     <= mant_d;
    guard_q    <= guard_d;
    sticky_q   <= sticky_d;
    sign_q     <= sign_d;
    left_q     <= left_d;
    fixed_q    <= fixed_d;
    fix_data_q <= fix_data_d;
    fix_inv_q  <= fix_inv_d;
    fix_inex_q <= fix_inex_d;
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign out_data    = out_data_q;
  assign out_invalid = out_invalid_q;
  assign out_inexact = out_inexact_q;

endmodule

// File: tb/tb_fp_to_int.sv
// Scoreboard bench for fp_to_int: directed vectors, random normals, backpressure and mid-op reset.
module tb_fp_to_int;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_invalid;
  logic        out_inexact;

  always #5 clk = ~clk;

  fp_to_int dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_invalid (out_invalid),
    .out_inexact (out_inexact)
  );

  typedef struct {
    logic [31:0] src;
    logic [31:0] data;
    logic        inv;
    logic        inex;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  bit   seen = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] src, input logic [31:0] data,
                              input logic inv, input logic inex, input int lat);
    exp_t e;
    e.src = src; e.data = data; e.inv = inv; e.inex = inex; e.lat = lat;
    return e;
  endfunction

  // Reference: exact integer division with remainder compared against half.
  function automatic exp_t model(input logic [31:0] f);
    exp_t   e;
    logic   s;
    int     ex, sh;
    longint m, q, rem, half;
    s  = f[31];
    ex = int'(f[30:23]);
    m  = longint'({1'b1, f[22:0]});
    e  = mk(f, 32'd0, 1'b0, 1'b0, 2);
    if (ex == 255) begin
      e.inv  = 1'b1;
      e.data = (f[22:0] != 0 || !s) ? 32'h7FFFFFFF : 32'h80000000;
    end else if (ex == 0) begin
      e.inex = (f[22:0] != 0);
    end else if (ex >= 158) begin
      e.data = s ? 32'h80000000 : 32'h7FFFFFFF;
      e.inv  = !(s && ex == 158 && f[22:0] == 0);
    end else if (ex < 126) begin
      e.inex = 1'b1;
    end else begin
      if (ex >= 150) begin
        q     = m << (ex - 150);
        e.lat = ex - 150 + 2;
      end else begin
        sh   = 150 - ex;
        q    = m >> sh;
        rem  = m - (q << sh);
        half = 64'sd1 <<< (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 1;
        e.inex = (rem != 0);
        e.lat  = sh + 2;
      end
      e.data = s ? 32'(-q) : 32'(q);
    end
    return e;
  endfunction

  always @(posedge clk) begin
    if (in_valid && in_ready && !rst) acc_cyc = cyc;
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    if (rst) begin
      seen = 1'b0;
    end else if (out_valid) begin
      if (sb_q.size() == 0) begin
        chk("spurious_out_valid", {31'd0, out_valid}, 32'd0);
      end else begin
        if (!seen) begin
          chk($sformatf("latency[%h]", sb_q[0].src), 32'(cyc - acc_cyc), 32'(sb_q[0].lat));
          seen = 1'b1;
        end
        chk($sformatf("data[%h]", sb_q[0].src), out_data, sb_q[0].data);
        chk($sformatf("invalid[%h]", sb_q[0].src), {31'd0, out_invalid}, {31'd0, sb_q[0].inv});
        chk($sformatf("inexact[%h]", sb_q[0].src), {31'd0, out_inexact}, {31'd0, sb_q[0].inex});
        chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
        if (out_ready) begin
          void'(sb_q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic send(input exp_t e);
    int t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = e.src;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("accept_timeout", {31'd0, in_ready}, 32'd1);
    else sb_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb_q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic wait_out_valid();
    int t = 0;
    while (!out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("wait_out_valid", {31'd0, out_valid}, 32'd1);
  endtask

  exp_t dir[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [7:0]  ex;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    out_ready = 1'b1;

    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_flags", {30'd0, out_invalid, out_inexact}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    dir.push_back(mk(32'h3FC00000, 32'h00000002, 1'b0, 1'b1, 25));
    dir.push_back(mk(32'h40200000, 32'h00000002, 1'b0, 1'b1, 24));
    dir.push_back(mk(32'hC1200000, 32'hFFFFFFF6, 1'b0, 1'b0, 22));
    dir.push_back(mk(32'h4F000000, 32'h7FFFFFFF, 1'b1, 1'b0, 2));
    dir.push_back(mk(32'hCF000000, 32'h80000000, 1'b0, 1'b0, 2));
    dir.push_back(mk(32'h7FC00000, 32'h7FFFFFFF, 1'b1, 1'b0, 2));
    dir.push_back(mk(32'h3E800000, 32'h00000000, 1'b0, 1'b1, 2));
    dir.push_back(mk(32'h00000001, 32'h00000000, 1'b0, 1'b1, 2));
    dir.push_back(mk(32'h4B000001, 32'h00800001, 1'b0, 1'b0, 2));
    dir.push_back(mk(32'h3F000000, 32'h00000000, 1'b0, 1'b1, 26));
    dir.push_back(mk(32'h3F400000, 32'h00000001, 1'b0, 1'b1, 26));
    dir.push_back(mk(32'hBFC00000, 32'hFFFFFFFE, 1'b0, 1'b1, 25));
    dir.push_back(mk(32'h4EFFFFFF, 32'h7FFFFF80, 1'b0, 1'b0, 9));
    dir.push_back(mk(32'hCF000001, 32'h80000000, 1'b1, 1'b0, 2));
    dir.push_back(mk(32'hFF800000, 32'h80000000, 1'b1, 1'b0, 2));
    dir.push_back(mk(32'h7F800000, 32'h7FFFFFFF, 1'b1, 1'b0, 2));
    dir.push_back(mk(32'h00000000, 32'h00000000, 1'b0, 1'b0, 2));
    dir.push_back(mk(32'h80000000, 32'h00000000, 1'b0, 1'b0, 2));
    dir.push_back(mk(32'h3F800000, 32'h00000001, 1'b0, 1'b0, 25));
    dir.push_back(mk(32'hC0400000, 32'hFFFFFFFD, 1'b0, 1'b0, 24));
    dir.push_back(mk(32'h4B7FFFFF, 32'h00FFFFFF, 1'b0, 1'b0, 2));
    dir.push_back(mk(32'h4B800000, 32'h01000000, 1'b0, 1'b0, 3));
    dir.push_back(mk(32'h3FE00000, 32'h00000002, 1'b0, 1'b1, 25));
    dir.push_back(mk(32'h40100000, 32'h00000002, 1'b0, 1'b1, 24));
    dir.push_back(mk(32'h40280000, 32'h00000003, 1'b0, 1'b1, 24));
    dir.push_back(mk(32'h40300000, 32'h00000003, 1'b0, 1'b1, 24));

    foreach (dir[i]) begin
      send(dir[i]);
      drain();
    end

    for (int i = 0; i < 16; i++) begin
      r  = $urandom;
      ex = 8'($urandom_range(120, 160));
      r  = {r[31], ex, r[22:0]};
      send(model(r));
      drain();
    end

    // Backpressure: result held 5 cycles while a second operand waits.
    out_ready = 1'b0;
    fork
      begin
        send(mk(32'h3F800000, 32'h00000001, 1'b0, 1'b0, 25));
        send(mk(32'h40400000, 32'h00000003, 1'b0, 1'b0, 24));
      end
      begin
        wait_out_valid();
        repeat (5) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset in the middle of the shift sequence.
    send(mk(32'h3FC00000, 32'h00000002, 1'b0, 1'b1, 25));
    repeat (5) @(negedge clk);
    rst = 1'b1;
    sb_q.delete();
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("post_rst_no_output", {31'd0, out_valid}, 32'd0);
    send(mk(32'h41200000, 32'h0000000A, 1'b0, 1'b0, 22));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fp_to_int.md
FP_TO_INT -- requirements
Module: fp_to_int

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-high reset.
REQ-002 SHALL expose: clk  in  1  clock; all state on rising edge.
REQ-003 SHALL expose: rst  in  1  asynchronous active-high reset.
REQ-004 SHALL expose: in_valid  in  1  in_data is valid this cycle.
REQ-005 SHALL expose: in_ready  out  1  block accepts in_data.
REQ-006 SHALL expose: in_data  in  32  IEEE-754 single (sign[31], exp[30:23], frac[22:0]).
REQ-007 SHALL expose: out_valid  out  1  out_data/flags are valid.
REQ-008 SHALL expose: out_ready  in  1  consumer takes the result.
REQ-009 SHALL expose: out_data  out  32  signed two's-complement int32 result.
REQ-010 SHALL expose: out_invalid  out  1  NaN, infinity or out-of-range input.
REQ-011 SHALL expose: out_inexact  out  1  nonzero fraction discarded by rounding.

Function
REQ-012 SHALL accept an operand on a cycle with in_valid && in_ready; in_ready SHALL be 1 only in IDLE.
REQ-013 SHALL implement states IDLE -> (SHIFT | ROUND) -> ROUND -> DONE -> IDLE.
REQ-014 Classification on accept: exp==255 -> special; exp>=158 -> overflow, except sign=1, exp=158, frac=0 (exact -2^31); exp<126 -> tiny; else normal.
REQ-015 Denormal inputs (exp==0) SHALL be treated as tiny: result 0, inexact = |frac.
REQ-016 Normal: mantissa = {1,frac}; shift count n = |exp-150|; left shift when exp>150 (n<=7), right shift when exp<150 (n<=24); exp==150 goes directly to ROUND.
REQ-017 SHIFT SHALL move exactly one bit per cycle, decrementing a 5-bit counter; right shifts SHALL track guard bit and OR all lower shifted-out bits into sticky.
REQ-018 ROUND SHALL apply round-to-nearest-even on guard/sticky/LSB, then two's-complement negate if sign=1; inexact = guard|sticky.
REQ-019 Specials/overflow/tiny SHALL skip SHIFT: one ROUND cycle producing the fixed result.
REQ-020 NaN or positive overflow/+inf SHALL give 0x7FFFFFFF, invalid=1; negative overflow/-inf SHALL give 0x80000000, invalid=1; exact -2^31 SHALL give 0x80000000 with no flags.
REQ-021 Latency: out_valid SHALL rise n+2 cycles after the accept edge (2 cycles when no SHIFT).
REQ-022 In DONE, out_valid=1 and out_data/flags SHALL hold stable until out_ready=1; on that edge return to IDLE.
REQ-023 An input offered while busy SHALL NOT be accepted; no queuing; the next accept is possible the cycle after the DONE handshake.

Reset
REQ-024 Reset SHALL force IDLE, in_ready=1, out_valid=0, out_data=0, out_invalid=0, out_inexact=0, counter=0.
REQ-025 Reset asserted mid-SHIFT/ROUND/DONE SHALL discard the operation; no partial result appears after release.

Structure
REQ-026 Package fpu_pkg SHALL hold FP32 field widths, bias 127, int anchor 150, saturation constants 0x7FFFFFFF/0x80000000, and the state enum.
REQ-027 Sub-module fp_unpack (combinational: field split, class: zero/denormal, normal, inf, NaN) SHALL be instantiated once; it is reused by other FPU blocks.

Verification
REQ-028 0x3FC00000 (1.5) -> 0x00000002, inexact=1, invalid=0, out_valid 25 cycles after accept.
REQ-029 0x40200000 (2.5) -> 0x00000002, inexact=1 (tie to even); 0xC1200000 (-10.0) -> 0xFFFFFFF6, no flags.
REQ-030 0x4F000000 -> 0x7FFFFFFF invalid=1; 0xCF000000 -> 0x80000000 no flags; 0x7FC00000 -> 0x7FFFFFFF invalid=1; all at latency 2.
REQ-031 0x3E800000 (0.25) -> 0, inexact=1; 0x00000001 denormal -> 0, inexact=1; 0x4B000001 (exp 150) -> 0x00800001, latency 2.
REQ-032 Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_data/flags stable, in_ready=0, second in_valid ignored until handshake.
REQ-033 Assert rst during SHIFT of 0x3FC00000 -> out_valid=0, in_ready=1 immediately; next operand 0x41200000 -> 0x0000000A correct.
